// File: rtl/ringosc_cnt_reader.sv
// Gate/freeze/readout controller for the ring-oscillator ripple counter; streams the 64-bit count LSB-first.
// Optional double-sample read verification: define RINGOSC_READER_VERIFY_EN.
module ringosc_cnt_reader #(
  parameter int GATE_LOG2  = 16,
  parameter int SETTLE     = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cnt_byte,
  output logic [5:0] cnt_shift,
  output logic       cnt_stop,
  output logic       cnt_reset,
  output logic       busy,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);
  localparam int TW = (GATE_LOG2 + 1 > 16) ? GATE_LOG2 + 1 : 16;
`ifdef RINGOSC_READER_VERIFY_EN
  localparam int RD_LEN = 2 * SETTLE;
`else
  localparam int RD_LEN = SETTLE;
`endif
  localparam logic [TW-1:0] CLR_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'((1 << GATE_LOG2) - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] RD_LAST     = TW'(RD_LEN - 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, HALT, READ, SEND} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tmr_reg, tmr_next;
  logic [2:0]    k_reg, k_next;
  logic [2:0]    j_reg, j_next;
  logic [7:0]    sync1_reg, sync2_reg;
  logic          capture;
  logic          last_try;
  logic [7:0]    res_byte [8];

  logic [5:0]    cnt_shift_reg;
  logic          cnt_stop_reg, cnt_reset_reg, busy_reg, out_valid_reg;
  logic [7:0]    out_data_reg;

  // cnt_byte is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= cnt_byte;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef RINGOSC_READER_VERIFY_EN
  logic [1:0] try_reg;
  logic [7:0] first_reg;
  logic       mismatch;
  logic       err_reg;

  assign mismatch = (sync2_reg != first_reg);
  assign last_try = !mismatch || (try_reg == 2'd2);
  assign err      = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      try_reg   <= '0;
      first_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == READ && tmr_reg == SETTLE_LAST)
        first_reg <= sync2_reg;
      if (state_reg == READ && tmr_reg == RD_LAST)
        try_reg <= last_try ? 2'd0 : try_reg + 2'd1;
      if (state_reg == IDLE && start)
        err_reg <= 1'b0;
      else if (capture && mismatch)
        err_reg <= 1'b1;
    end
  end
`else
  assign last_try = 1'b1;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg + 1'b1;
    k_next     = k_reg;
    j_next     = j_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        tmr_next = '0;
        if (start) begin
          state_next = CLR;
          k_next     = '0;
          j_next     = '0;
        end
      end
      CLR: if (tmr_reg == CLR_LAST) begin
        state_next = RUN;
        tmr_next   = '0;
      end
      RUN: if (tmr_reg == GATE_LAST) begin
        state_next = HALT;
        tmr_next   = '0;
      end
      HALT: if (tmr_reg == SETTLE_LAST) begin
        state_next = READ;
        tmr_next   = '0;
        k_next     = '0;
      end
      READ: if (tmr_reg == RD_LAST) begin
        // a failed verify restarts the same byte with the shift unchanged
        tmr_next = '0;
        if (last_try) begin
          capture = 1'b1;
          if (k_reg == 3'd7) begin
            state_next = SEND;
            j_next     = '0;
          end else begin
            k_next = k_reg + 3'd1;
          end
        end
      end
      SEND: begin
        tmr_next = '0;
        if (out_valid_reg && out_ready) begin
          if (j_reg == 3'd7) state_next = IDLE;
          else               j_next     = j_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] byte_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        byte_reg <= '0;
      else if (capture && k_reg == 3'(gi))
        byte_reg <= sync2_reg;
    end
    assign res_byte[gi] = byte_reg;
  end

  // Counter controls are registered from the next state so the gate is exactly RUN's length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tmr_reg       <= '0;
      k_reg         <= '0;
      j_reg         <= '0;
      cnt_stop_reg  <= 1'b1;
      cnt_reset_reg <= 1'b1;
      cnt_shift_reg <= '0;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      tmr_reg       <= tmr_next;
      k_reg         <= k_next;
      j_reg         <= j_next;
      cnt_stop_reg  <= (state_next != RUN);
      cnt_reset_reg <= (state_next == IDLE) || (state_next == CLR);
      cnt_shift_reg <= (state_next == READ) ? {k_next, 3'b000} : 6'd0;
      busy_reg      <= (state_next != IDLE);
      out_valid_reg <= (state_next == SEND);
      if (state_next == SEND)
        out_data_reg <= res_byte[j_next];
    end
  end

  assign cnt_shift = cnt_shift_reg;
  assign cnt_stop  = cnt_stop_reg;
  assign cnt_reset = cnt_reset_reg;
  assign busy      = busy_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
endmodule

// File: doc/ringosc_cnt_reader.md
# ringosc_cnt_reader

Synchronous controller and readout engine for the ring-oscillator ripple counter. It runs in the `clk` domain and drives the counter's stop, reset and shift controls. It opens a fixed gate window, freezes the counter, then reads the 64-bit count back one byte at a time through the counter's shifted byte output. The captured count is streamed out LSB-first over a valid/ready byte interface, giving software a frequency measurement of the oscillator.

## Interface
- `GATE_LOG2`, 16: gate window length is 2^GATE_LOG2 `clk` cycles; legal range 4..24.
- `SETTLE`, 4: `clk` cycles waited after any change to stop or shift before sampling; minimum 3, because of the 2-flop synchronizer.
- `RST_CYCLES`, 2: `clk` cycles for which `cnt_reset` is held at the start of a run; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle pulse that begins a measurement; ignored while `busy`.
- `cnt_byte`  in  8  shifted counter byte (count >> `cnt_shift`)[7:0]; asynchronous to `clk`.
- `cnt_shift`  out  6  counter byte select; only multiples of 8 are driven.
- `cnt_stop`  out  1  1 = oscillator halted.
- `cnt_reset`  out  1  1 = counter cleared.
- `busy`  out  1  high from the cycle after an accepted `start` until the last byte transfers.
- `out_data`  out  8  result byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte.
- `err`  out  1  read-verify mismatch seen; only exists with the macro, otherwise tied 0.

## Operation
- **Reset values:** `cnt_stop`=1, `cnt_reset`=1, `cnt_shift`=0, `busy`=0, `out_valid`=0, `out_data`=0, `err`=0. FSM in IDLE.
- **FSM states:** IDLE, CLR, RUN, HALT, READ, SEND.
- **IDLE:** holds `cnt_stop`=1 and `cnt_reset`=1. On `start` -> CLR.
- **CLR:** `cnt_reset`=1, `cnt_stop`=1 for RST_CYCLES cycles -> RUN.
- **RUN:** `cnt_reset`=0, `cnt_stop`=0. A timer of width GATE_LOG2+1 counts 2^GATE_LOG2 cycles -> HALT.
- **HALT:** `cnt_stop`=1. Wait SETTLE cycles so the ripple chain can finish -> READ with byte index k=0.
- **READ:** `cnt_shift`=8k. After SETTLE cycles, capture the output of the 2-flop synchronizer on `cnt_byte` into `res[8k+7:8k]`. Increment k. After k=7 -> SEND with send index j=0.
- **SEND:** `out_valid`=1, `out_data`=`res[8j+7:8j]`. A transfer occurs on a cycle with `out_valid` and `out_ready` both high. After the 8th transfer: `out_valid`=0, `busy`=0, return to IDLE with `cnt_reset`=1.
- **Handshake rules:** once `out_valid` is asserted, it and `out_data` hold until transfer. `out_ready` may be high before `out_valid`.
- **Boundary conditions:**
  - `start` while busy is dropped; no queueing.
  - `start` on the same cycle the last byte transfers is dropped; `busy` is still high in that cycle.
  - `rst_n` low at any point returns all outputs to reset values immediately. A partial result is discarded.
  - Counter overflow past 2^64 wraps silently; no flag.

## Timing
- Latency from `start` to the first `out_valid` = 1 + RST_CYCLES + 2^GATE_LOG2 + SETTLE + 8·SETTLE cycles. With defaults that is 65,575 cycles.
- With `out_ready` held high, SEND takes exactly 8 cycles, one byte per cycle.
- `cnt_shift`, `cnt_stop` and `cnt_reset` are driven directly from flops, with no combinational path from inputs.
- The gate window is exact: `cnt_stop` is low for exactly 2^GATE_LOG2 cycles.

## Configuration
- **Macro:** `RINGOSC_READER_VERIFY_EN`.
- **Defined:** each byte is sampled twice, SETTLE cycles apart. On a mismatch the byte is re-read, up to 3 attempts. If the third attempt still mismatches, the last sample is kept and `err` is set. `err` is sticky until the next accepted `start` or until reset. READ latency per byte grows to 2·SETTLE cycles minimum.
- **Undefined:** a single sample per byte; `err` is constant 0.

## Test plan
- **Basic measurement:** bench counter model advances 3 counts per `clk` while unstopped; GATE_LOG2=4 -> 8 bytes 0x30,0,0,0,0,0,0,0 in order, with `busy` low after the 8th transfer.
- **Backpressure:** `out_ready` toggles 1,0,0,1,... -> every byte is delivered exactly once, and `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- **Full-width readout:** model preloaded to 0x0123456789ABCDEF at halt -> bytes 0xEF,0xCD,0xAB,0x89,0x67,0x45,0x23,0x01; `cnt_shift` steps through 0,8,…,56.
- **Start while busy:** `start` pulsed during RUN and again during SEND -> exactly one 8-byte result, and the gate length is unchanged.
- **Mid-operation reset:** `rst_n` low during READ k=3 -> all outputs return to reset values in the same cycle; the next `start` yields a correct fresh result.
- **Verify mode** (`RINGOSC_READER_VERIFY_EN` defined): model corrupts every sample of byte 2 -> `err`=1 and 8 bytes are still sent. A following clean run clears `err`.
